apb_master_bridge: RTL and testbench

- APB requester (initiator) that drives the APB bus toward the I2C core's APB completer.
- Turns a simple single-outstanding command interface (from a CPU-side sequencer or test controller) into compliant APB SETUP/ACCESS transfers.
- Returns read data and slave error on a one-cycle response strobe.
- Targets the completer register map: 0x0 TX FIFO, 0x4 RX FIFO, 0x8 CONFIG, 0xC TIMEOUT.

---
 rtl/apb_master_pkg.sv | 17 +
 rtl/apb_master_timeout.sv | 33 +++
 rtl/apb_master_bridge.sv | 142 ++++++++++++++
 tb/tb_apb_master_bridge.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_pkg.sv
// Shared types and register-map constants for the APB master bridge.
// The optional ACCESS-phase timeout is enabled with APB_MASTER_TIMEOUT_EN.
package apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Completer register map (I2C core)
  localparam logic [31:0] ADDR_TX_FIFO     = 32'd0;
  localparam logic [31:0] ADDR_RX_FIFO     = 32'd4;
  localparam logic [31:0] ADDR_I2C_CONFIG  = 32'd8;
  localparam logic [31:0] ADDR_I2C_TIMEOUT = 32'd12;

endpackage

// File: rtl/apb_master_timeout.sv
// ACCESS-phase wait-state counter with expiry compare; instantiated by
// apb_master_bridge only when APB_MASTER_TIMEOUT_EN is defined.
module apb_master_timeout
  import apb_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_wait,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_count;

  // Count ACCESS cycles spent with PREADY low; restart on each new transfer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_wait) begin
      r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // The cycle being counted now is the last one allowed.
  assign o_expired = i_wait && (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding command to APB requester bridge (IDLE/SETUP/ACCESS).
// Optional ACCESS timeout abort is enabled with APB_MASTER_TIMEOUT_EN.
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSELx,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  apb_state_e        r_state;
  logic              r_cmd_ready;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_rsp_timeout;

  logic              w_accept;
  logic              w_expire;

  assign w_accept = r_cmd_ready && cmd_valid;

`ifdef APB_MASTER_TIMEOUT_EN
  logic w_wait;

  assign w_wait = (r_state == ACCESS) && !PREADY;

  apb_master_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk    (PCLK),
    .i_rst_n  (PRESETn),
    .i_clear  (w_accept),
    .i_wait   (w_wait),
    .o_expired(w_expire)
  );
`else
  // Without the timeout option ACCESS waits forever.
  assign w_expire = 1'b0 && (TIMEOUT_CYCLES >= 1);
`endif

  // Transfer sequencer; every bus and response output is a register here.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state       <= IDLE;
      r_cmd_ready   <= 1'b1;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_pwrite    <= cmd_write;
            r_paddr     <= cmd_addr;
            r_pwdata    <= cmd_wdata;
            r_psel      <= 1'b1;
            r_cmd_ready <= 1'b0;
            r_state     <= SETUP;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          // Completion beats a timeout that expires on the same edge.
          if (PREADY) begin
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_err     <= PSLVERR;
            r_rsp_timeout <= 1'b0;
            r_cmd_ready   <= 1'b1;
            r_state       <= IDLE;
            if (!r_pwrite) begin
              r_rsp_rdata <= PRDATA;
            end
          end else if (w_expire) begin
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_cmd_ready   <= 1'b1;
            r_state       <= IDLE;
          end
        end
        default: begin
          r_psel      <= 1'b0;
          r_penable   <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign PSELx       = r_psel;
  assign PENABLE     = r_penable;
  assign PWRITE      = r_pwrite;
  assign PADDR       = r_paddr;
  assign PWDATA      = r_pwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed table, corner sequences,
// and random transfers against a transaction-level response model.
module tb_apb_master_bridge;

  localparam int TO_LIMIT = 16;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        PCLK;
  logic        PRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        PSELx;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int n_checks = 0;
  int n_fail   = 0;

  // Response model: what rsp_rdata/rsp_err should hold after the last strobe.
  logic [31:0] m_rdata;
  logic        m_err;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] rdata;
    bit          slverr;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs[6];

  apb_master_bridge #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO_LIMIT)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit rbit();
    return 1'($urandom & 32'd1);
  endfunction

  function automatic bit timeout_hit(input int waits);
    return TO_EN && (waits >= TO_LIMIT);
  endfunction

  // Expected response of one transfer, from the rules alone.
  task automatic predict(input bit wr, input int waits, input logic [31:0] rdata,
                         input bit slverr, output logic [31:0] er, output bit ee);
    bit ab;
    ab = timeout_hit(waits);
    er = (!wr && !ab) ? rdata : m_rdata;
    ee = ab || slverr;
  endtask

  // Drives one command and acts as the APB completer with 'waits' wait states.
  task automatic run_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int waits, input logic [31:0] rdata, input bit slverr,
                          input logic [31:0] exp_rdata, input bit exp_err, input bit keep_valid);
    bit ab;
    bit done;
    int acc;
    ab = timeout_hit(waits);
    check("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    PREADY = rbit(); PSLVERR = rbit(); PRDATA = $urandom;
    @(negedge PCLK);
    check("setup_psel", PSELx, 1);
    check("setup_penable", PENABLE, 0);
    check("setup_paddr", PADDR, addr);
    check("setup_pwrite", PWRITE, wr);
    check("setup_pwdata", PWDATA, wdata);
    check("setup_ready", cmd_ready, 0);
    check("setup_rspv", rsp_valid, 0);
    cmd_valid = keep_valid ? 1'b1 : rbit();
    cmd_write = rbit(); cmd_addr = $urandom; cmd_wdata = $urandom;
    PREADY = rbit(); PSLVERR = rbit(); PRDATA = $urandom;
    @(negedge PCLK);
    acc = 0;
    done = 1'b0;
    while (!done) begin
      check("acc_psel", PSELx, 1);
      check("acc_penable", PENABLE, 1);
      check("acc_paddr", PADDR, addr);
      check("acc_pwrite", PWRITE, wr);
      check("acc_pwdata", PWDATA, wdata);
      check("acc_ready", cmd_ready, 0);
      check("acc_rspv", rsp_valid, 0);
      if (acc == waits) begin
        PREADY = 1'b1; PRDATA = rdata; PSLVERR = slverr;
      end else begin
        PREADY = 1'b0; PRDATA = $urandom; PSLVERR = rbit();
      end
      cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = rbit();
      acc++;
      @(negedge PCLK);
      if (acc > waits || (ab && acc >= TO_LIMIT)) done = 1'b1;
    end
    PREADY = 1'b0; PSLVERR = rbit(); PRDATA = $urandom;
    check("end_rspv", rsp_valid, 1);
    check("end_psel", PSELx, 0);
    check("end_penable", PENABLE, 0);
    check("end_ready", cmd_ready, 1);
    check("end_paddr_hold", PADDR, addr);
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("rsp_err", rsp_err, exp_err);
    check("rsp_timeout", rsp_timeout, ab);
    m_rdata = exp_rdata;
    m_err = exp_err;
    cmd_valid = keep_valid;
  endtask

  task automatic model_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input int waits, input logic [31:0] rdata, input bit slverr,
                            input bit keep_valid);
    logic [31:0] er;
    bit ee;
    predict(wr, waits, rdata, slverr, er, ee);
    run_xfer(wr, addr, wdata, waits, rdata, slverr, er, ee, keep_valid);
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'd8,  32'h0000_1234, 0, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b0};
    vecs[1] = '{1'b0, 32'd4,  32'h0000_0000, 3, 32'hA5A5_0001, 1'b0, 32'hA5A5_0001, 1'b0};
    vecs[2] = '{1'b1, 32'd0,  32'h0000_CAFE, 0, 32'h1111_1111, 1'b1, 32'hA5A5_0001, 1'b1};
    vecs[3] = '{1'b1, 32'd0,  32'h0000_0055, 1, 32'h2222_2222, 1'b0, 32'hA5A5_0001, 1'b0};
    vecs[4] = '{1'b0, 32'd8,  32'h7777_0000, 2, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b1};
    vecs[5] = '{1'b0, 32'd12, 32'h0000_0000, 0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};

    PRESETn = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    m_rdata = '0; m_err = 1'b0;
    #2 PRESETn = 1'b0;
    #1;
    check("rst_psel", PSELx, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_rspv", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_err", rsp_err, 0);
    check("rst_to", rsp_timeout, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_pwrite", PWRITE, 0);
    @(negedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("rst_ready", cmd_ready, 1);

    for (int i = 0; i < 6; i++) begin
      run_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].waits, vecs[i].rdata,
               vecs[i].slverr, vecs[i].exp_rdata, vecs[i].exp_err, 1'b0);
    end

    // Back-to-back writes with cmd_valid held high.
    model_xfer(1'b1, 32'd8,  32'h0000_0011, 0, 32'h0, 1'b0, 1'b1);
    model_xfer(1'b1, 32'd12, 32'h0000_0022, 0, 32'h0, 1'b0, 1'b0);

    // Idle: bus holds, no strobes, responses hold.
    for (int i = 0; i < 3; i++) begin
      PREADY = rbit(); PSLVERR = rbit(); PRDATA = $urandom;
      @(negedge PCLK);
      check("idle_psel", PSELx, 0);
      check("idle_penable", PENABLE, 0);
      check("idle_paddr", PADDR, 32'd12);
      check("idle_pwdata", PWDATA, 32'h0000_0022);
      check("idle_pwrite", PWRITE, 1);
      check("idle_rspv", rsp_valid, 0);
      check("idle_rdata", rsp_rdata, m_rdata);
      check("idle_err", rsp_err, m_err);
    end

    // Reset in the middle of ACCESS.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'd4; cmd_wdata = 32'h0BAD_0BAD;
    @(negedge PCLK);
    cmd_valid = 1'b0; PREADY = 1'b0;
    @(negedge PCLK);
    check("pre_rst_penable", PENABLE, 1);
    #2 PRESETn = 1'b0;
    #1;
    check("mid_rst_psel", PSELx, 0);
    check("mid_rst_penable", PENABLE, 0);
    check("mid_rst_pwrite", PWRITE, 0);
    check("mid_rst_paddr", PADDR, 0);
    check("mid_rst_pwdata", PWDATA, 0);
    check("mid_rst_rspv", rsp_valid, 0);
    check("mid_rst_rdata", rsp_rdata, 0);
    check("mid_rst_err", rsp_err, 0);
    check("mid_rst_to", rsp_timeout, 0);
    m_rdata = '0; m_err = 1'b0;
    PREADY = 1'b1; PRDATA = 32'hFFFF_0000;
    @(negedge PCLK);
    PRESETn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge PCLK);
      check("post_rst_rspv", rsp_valid, 0);
      check("post_rst_psel", PSELx, 0);
      check("post_rst_ready", cmd_ready, 1);
    end

    // Wait-limit boundaries: ready on the 16th ACCESS cycle, then never ready.
    model_xfer(1'b0, 32'd4, 32'h0, TO_LIMIT - 1, 32'h0000_600D, 1'b0, 1'b0);
    model_xfer(1'b0, 32'd4, 32'h0, TO_LIMIT, 32'h0000_0BAD, 1'b0, 1'b0);
    model_xfer(1'b0, 32'd8, 32'h0, 40, 32'h1234_5678, 1'b1, 1'b0);

    for (int i = 0; i < 150; i++) begin
      int w;
      w = (($urandom & 32'd7) == 32'd0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 4));
      model_xfer(rbit(), {28'd0, 2'($urandom), 2'b00}, $urandom, w, $urandom, rbit(),
                 (i < 149) ? rbit() : 1'b0);
    end

    @(negedge PCLK);
    check("final_psel", PSELx, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
